// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and helpers for the memory-access stage: register bus widths,
// memory-op codes, RV32I load/store funct3 constants, FSM state encoding and
// the size/strobe/replication helpers used when a request is captured.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'b00,
    MEM_OP_LOAD  = 2'b01,
    MEM_OP_STORE = 2'b10,
    MEM_OP_RSVD  = 2'b11
  } mem_op_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  // funct3[1:0] carries the access width for both loads and stores; any
  // unlisted encoding falls back to a full word.
  function automatic size_e decode_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] offset);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      default: return (offset != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_strobe(input size_e sz, input logic [1:0] offset);
    case (sz)
      SZ_BYTE: return 4'b0001 << offset;
      SZ_HALF: return 4'b0011 << {offset[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating across lanes lets the memory pick the right lane purely from
  // the strobes, independent of the address offset.
  function automatic logic [RegBus-1:0] replicate_store(input size_e sz,
                                                        input logic [RegBus-1:0] data);
    case (sz)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Data-memory request/grant/response bundle.
//   req/wr/addr/wdata/be : request, driven by the pipeline (master)
//   gnt                  : request accepted, driven by memory (slave)
//   rvalid/rdata         : load response, driven by memory (slave)
// -----------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        be;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wr, addr, wdata, be,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// mem_stage_load_align
// Combinational load-data alignment: picks the addressed byte/halfword lane
// out of a memory word and sign- or zero-extends it. Kept separate so a future
// cache can reuse it on its own read path.
//   rdata_i  : raw memory word
//   offset_i : byte offset (addr[1:0]) of the access
//   funct3_i : RV32I load funct3 (size + unsigned flag)
//   data_o   : register-ready value
// -----------------------------------------------------------------------------
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [RegBus-1:0] rdata_i,
  input  logic [1:0]        offset_i,
  input  logic [2:0]        funct3_i,
  output logic [RegBus-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        ext_b;
  logic        ext_h;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // funct3[2] marks the unsigned variants (LBU/LHU)
    ext_b = ~funct3_i[2] & byte_sel[7];
    ext_h = ~funct3_i[2] & half_sel[15];

    case (decode_size(funct3_i))
      SZ_BYTE: data_o = {{24{ext_b}}, byte_sel};
      SZ_HALF: data_o = {{16{ext_h}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage between EX/MEM and MEM/WB. ALU results pass straight
// through; loads and stores run a req/gnt/rvalid handshake with data memory
// while stall_req_o holds the earlier stages.
//
// Ports
//   clk, rst_n            : clock, async active-low reset
//   ex_reg_waddr_i        : destination register
//   ex_we_i / ex_wdata_i  : register write enable / ALU result
//   ex_mem_op_i           : 00 none, 01 load, 10 store, 11 none
//   ex_funct3_i           : RV32I access size and sign
//   ex_mem_addr_i         : effective byte address
//   ex_store_data_i       : rs2 value
//   mem_reg_waddr_o, mem_we_o, mem_wdata_o : to MEM/WB
//   stall_req_o           : hold PC, IF/ID, ID/EX, EX/MEM
//   misalign_o            : misaligned-access pulse
//   dmem                  : data-memory request/response bundle (master)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | decode; pass ALU results through, or capture a memory request
// REQ   | dmem req asserted with stable fields, waiting for gnt
// WAIT  | load granted, waiting for rvalid (earliest the cycle after gnt)
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = RegBus
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [RegAddrBus-1:0] ex_reg_waddr_i,
  input  logic                  ex_we_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic [1:0]            ex_mem_op_i,
  input  logic [2:0]            ex_funct3_i,
  input  logic [ADDR_W-1:0]     ex_mem_addr_i,
  input  logic [DATA_W-1:0]     ex_store_data_i,

  output logic [RegAddrBus-1:0] mem_reg_waddr_o,
  output logic                  mem_we_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic                  stall_req_o,
  output logic                  misalign_o,

  mem_stage_if.master           dmem
);

  state_e            state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic              wr_q;
  logic [2:0]        funct3_q;

  logic              is_load;
  logic              is_store;
  logic              is_mem;
  size_e             size;
  logic              mis;
  logic              capture;
  logic [DATA_W-1:0] load_data;

  logic              stall_d;
  logic              we_d;
  logic [DATA_W-1:0] wdata_d;
  logic              misalign_d;
  logic              req_d;

  always_comb begin
    is_load  = (mem_op_e'(ex_mem_op_i) == MEM_OP_LOAD);
    is_store = (mem_op_e'(ex_mem_op_i) == MEM_OP_STORE);
    is_mem   = is_load | is_store;
    size     = decode_size(ex_funct3_i);
    mis      = is_misaligned(size, ex_mem_addr_i[1:0]);
  end

  mem_stage_load_align u_load_align (
    .rdata_i  (dmem.rdata),
    .offset_i (addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    stall_d    = 1'b0;
    we_d       = ex_we_i;
    wdata_d    = ex_wdata_i;
    misalign_d = 1'b0;
    req_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          we_d = 1'b0;
          if (mis) begin
            // Dropped without a request; the pipeline moves on and the
            // exception logic takes over.
            misalign_d = 1'b1;
          end else begin
            stall_d = 1'b1;
            capture = 1'b1;
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        req_d   = 1'b1;
        we_d    = 1'b0;
        stall_d = 1'b1;
        if (dmem.gnt) begin
          if (wr_q) begin
            stall_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        we_d    = 1'b0;
        stall_d = 1'b1;
        if (dmem.rvalid) begin
          stall_d = 1'b0;
          we_d    = ex_we_i;
          wdata_d = load_data;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
      funct3_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q   <= ex_mem_addr_i;
        wdata_q  <= replicate_store(size, ex_store_data_i);
        be_q     <= byte_strobe(size, ex_mem_addr_i[1:0]);
        wr_q     <= is_store;
        funct3_q <= ex_funct3_i;
      end
    end
  end

  // Control outputs are forced low while reset is held, even if EX/MEM
  // still presents a memory op.
  assign stall_req_o     = stall_d & rst_n;
  assign mem_we_o        = we_d & rst_n;
  assign misalign_o      = misalign_d & rst_n;
  assign mem_wdata_o     = wdata_d;
  assign mem_reg_waddr_o = ex_reg_waddr_i;

  assign dmem.req   = req_d;
  assign dmem.wr    = wr_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ex_reg_waddr;
  logic        ex_we;
  logic [31:0] ex_wdata;
  logic [1:0]  ex_mem_op;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  mem_reg_waddr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        stall_req;
  logic        misalign;

  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_W(32), .DATA_W(32)) dmem_if ();

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_reg_waddr_i  (ex_reg_waddr),
    .ex_we_i         (ex_we),
    .ex_wdata_i      (ex_wdata),
    .ex_mem_op_i     (ex_mem_op),
    .ex_funct3_i     (ex_funct3),
    .ex_mem_addr_i   (ex_mem_addr),
    .ex_store_data_i (ex_store_data),
    .mem_reg_waddr_o (mem_reg_waddr),
    .mem_we_o        (mem_we),
    .mem_wdata_o     (mem_wdata),
    .stall_req_o     (stall_req),
    .misalign_o      (misalign),
    .dmem            (dmem_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wdata;
    logic        mis;
    int          stalls;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  rsp_t rsp_q[$];
  req_t req_q[$];

  logic        op_valid = 1'b0;
  logic        stray_en = 1'b0;
  int          plan_gnt_dly = 0;
  int          plan_rv_dly = 0;
  logic [31:0] plan_rdata = '0;
  logic        rv_pending = 1'b0;
  int          rv_cnt = 0;
  int          g_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic req_t model_req(input logic wr, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] sd);
    req_t r;
    int n = size_bytes(f3);
    int off = int'(addr % 4);
    r.addr = addr;
    r.wr   = wr;
    r.be   = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = sd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int n = size_bytes(f3);
    int off = int'(addr % 4);
    logic [63:0] v, mask;
    v    = {32'b0, rdata} >> (8 * off);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v    = v & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------- memory slave ----------------
  initial begin
    dmem_if.gnt    = 1'b0;
    dmem_if.rvalid = 1'b0;
    dmem_if.rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      dmem_if.gnt    = 1'b0;
      dmem_if.rvalid = 1'b0;
      dmem_if.rdata  = $urandom;
      if (rv_pending) begin
        if (rv_cnt == 0) begin
          dmem_if.rvalid = 1'b1;
          dmem_if.rdata  = plan_rdata;
          rv_pending     = 1'b0;
        end else begin
          rv_cnt--;
        end
      end else if (stray_en && $urandom_range(3) == 0) begin
        dmem_if.rvalid = 1'b1;
      end
      if (dmem_if.req) begin
        if (g_cnt >= plan_gnt_dly) begin
          dmem_if.gnt = 1'b1;
          g_cnt = 0;
          if (!dmem_if.wr) begin
            rv_pending = 1'b1;
            rv_cnt     = plan_rv_dly;
          end
        end else begin
          g_cnt++;
        end
      end
    end
  end

  // ---------------- request monitor: fields checked every req cycle ----------------
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      if (rst_n && dmem_if.req) begin
        if (req_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_req: got req=1 addr=0x%08h expected no request at %0t",
                   dmem_if.addr, $time);
        end else begin
          e = req_q[0];
          check("req_addr", dmem_if.addr, e.addr);
          check("req_wr", {31'b0, dmem_if.wr}, {31'b0, e.wr});
          if (e.wr) begin
            check("req_be", {28'b0, dmem_if.be}, {28'b0, e.be});
            check("req_wdata", dmem_if.wdata, e.wdata);
          end
          if (dmem_if.gnt) void'(req_q.pop_front());
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    rsp_t e;
    int stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n && op_valid) begin
        if (stall_req) begin
          stall_cnt++;
          check("we_during_stall", {31'b0, mem_we}, 32'd0);
          check("misalign_during_stall", {31'b0, misalign}, 32'd0);
        end else begin
          if (rsp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_retire: got retire expected none at %0t", $time);
          end else begin
            e = rsp_q.pop_front();
            check("rd", {27'b0, mem_reg_waddr}, {27'b0, e.rd});
            check("we", {31'b0, mem_we}, {31'b0, e.we});
            check("misalign", {31'b0, misalign}, {31'b0, e.mis});
            check("stall_cycles", stall_cnt, e.stalls);
            if (e.we) check("wdata", mem_wdata, e.wdata);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] rd, input logic we,
                       input logic [31:0] alu, input int gd, input int rvd,
                       input logic [31:0] rdata);
    rsp_t r;
    int   n = size_bytes(f3);
    int   k = 0;
    r.rd = rd; r.we = we; r.wdata = alu; r.mis = 1'b0; r.stalls = 0;
    if (op == 2'b01 || op == 2'b10) begin
      r.we = 1'b0;
      if (addr % n != 0) begin
        r.mis = 1'b1;
      end else if (op == 2'b10) begin
        r.stalls = 1 + gd;
        req_q.push_back(model_req(1'b1, f3, addr, sd));
      end else begin
        r.we     = we;
        r.wdata  = model_load(f3, addr, rdata);
        r.stalls = 2 + gd + rvd;
        req_q.push_back(model_req(1'b0, f3, addr, sd));
      end
    end
    rsp_q.push_back(r);
    plan_gnt_dly = gd; plan_rv_dly = rvd; plan_rdata = rdata;
    ex_mem_op = op; ex_funct3 = f3; ex_mem_addr = addr; ex_store_data = sd;
    ex_reg_waddr = rd; ex_we = we; ex_wdata = alu;
    op_valid = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (stall_req && k < 60);
    if (k >= 60) begin
      n_cmp++;
      n_bad++;
      $display("FAIL retire_timeout: got stall still high expected retire within 60 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0;
    ex_mem_op = 2'b00; ex_funct3 = '0; ex_mem_addr = '0; ex_store_data = '0;
    ex_reg_waddr = '0; ex_we = 1'b0; ex_wdata = '0;
  endtask

  logic [2:0] ld_f3 [6];
  initial begin
    ld_f3[0] = F3_LB; ld_f3[1] = F3_LH; ld_f3[2] = F3_LW;
    ld_f3[3] = F3_LBU; ld_f3[4] = F3_LHU; ld_f3[5] = 3'b110;
  end

  initial begin
    int k;
    rst_n = 1'b0;
    idle_inputs();
    ex_mem_op = 2'b01;
    repeat (2) @(negedge clk);
    check("rst_stall", {31'b0, stall_req}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_req", {31'b0, dmem_if.req}, 32'd0);
    check("rst_addr", dmem_if.addr, 32'd0);
    check("rst_be", {28'b0, dmem_if.be}, 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed cases
    issue(2'b00, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 0, 32'h0);
    issue(2'b11, 3'b010, 32'h101, 32'h0, 5'd7, 1'b1, 32'hCAFE_0001, 0, 0, 32'h0);
    issue(2'b01, F3_LB, 32'h103, 32'h0, 5'd3, 1'b1, 32'h0, 0, 0, 32'h80FF_FF00);
    issue(2'b01, F3_LHU, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0, 0, 0, 32'h8001_0000);
    issue(2'b01, F3_LH, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0, 1, 2, 32'h8001_0000);
    issue(2'b01, F3_LBU, 32'h101, 32'h0, 5'd9, 1'b1, 32'h0, 0, 1, 32'h0000_F100);
    issue(2'b10, F3_SH, 32'h102, 32'h0000_ABCD, 5'd0, 1'b0, 32'h0, 0, 0, 32'h0);
    issue(2'b10, F3_SW, 32'h200, 32'h1234_5678, 5'd0, 1'b0, 32'h0, 3, 0, 32'h0);
    for (int o = 0; o < 4; o++)
      issue(2'b10, F3_SB, 32'h300 + o, 32'h0000_00A5 + o, 5'd0, 1'b0, 32'h0, o % 2, 0, 32'h0);
    issue(2'b01, F3_LW, 32'h101, 32'h0, 5'd6, 1'b1, 32'h0, 0, 0, 32'h0);
    issue(2'b10, F3_SH, 32'h103, 32'hFFFF, 5'd0, 1'b0, 32'h0, 0, 0, 32'h0);
    issue(2'b01, F3_LW, 32'h104, 32'h0, 5'd0, 1'b1, 32'h0, 2, 3, 32'hDEAD_BEEF);

    // reset while a load sits in WAIT; its late response must be dropped
    idle_inputs();
    stray_en = 1'b0;
    req_q.push_back(model_req(1'b0, F3_LW, 32'h400, 32'h0));
    plan_gnt_dly = 0; plan_rv_dly = 4; plan_rdata = 32'h5555_AAAA;
    ex_mem_op = 2'b01; ex_funct3 = F3_LW; ex_mem_addr = 32'h400; ex_we = 1'b1; ex_reg_waddr = 5'd8;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_stall", {31'b0, stall_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_wait_stall", {31'b0, stall_req}, 32'd0);
    check("rst_wait_we", {31'b0, mem_we}, 32'd0);
    check("rst_wait_req", {31'b0, dmem_if.req}, 32'd0);
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_stall", {31'b0, stall_req}, 32'd0);
      check("post_rst_we", {31'b0, mem_we}, 32'd0);
      check("post_rst_wdata", mem_wdata, 32'd0);
    end
    k = 0;
    while (rv_pending && k < 20) begin @(negedge clk); k++; end
    check("late_rvalid_drained", {31'b0, rv_pending}, 32'd0);
    @(posedge clk); #1;
    issue(2'b01, F3_LH, 32'h406, 32'h0, 5'd10, 1'b1, 32'h0, 0, 0, 32'h7FFF_0000);

    // randomized traffic
    stray_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      op   = 2'($urandom_range(3));
      f3   = (op == 2'b10) ? 3'($urandom_range(2)) : ld_f3[$urandom_range(5)];
      addr = $urandom;
      if ($urandom_range(1) == 0) addr[1:0] = 2'b00;
      issue(op, f3, addr, $urandom, 5'($urandom), 1'($urandom), $urandom,
            $urandom_range(3), $urandom_range(3), $urandom);
      if ($urandom_range(7) == 0) begin
        idle_inputs();
        repeat ($urandom_range(3)) @(posedge clk);
        #1;
      end
    end

    idle_inputs();
    repeat (4) @(negedge clk);
    check("rsp_queue_empty", rsp_q.size(), 32'd0);
    check("req_queue_empty", req_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
